// File: rtl/clock_pkg.sv
// Shared encodings for the clock front end: mode states, BCD limits, blank-mask bit positions.
// Latency: none (constants and pure functions). Backpressure: none.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam logic [3:0] BCD_ONES_MAX       = 4'd9;
  localparam logic [3:0] BCD_MIN_TENS_MAX   = 4'd5;
  localparam logic [3:0] BCD_HOUR_TENS_MAX  = 4'd2;
  localparam logic [3:0] BCD_HOUR_ONES_LAST = 4'd3;
  localparam logic [7:0] HOUR_MAX_BCD       = {BCD_HOUR_TENS_MAX, BCD_HOUR_ONES_LAST};  // 23
  localparam logic [7:0] MIN_MAX_BCD        = {BCD_MIN_TENS_MAX, BCD_ONES_MAX};         // 59
  localparam logic [5:0] SEC_MAX            = 6'd59;

  // digit_blank bit positions, shared with the display multiplexer
  localparam int BLANK_HOUR_TENS = 3;
  localparam int BLANK_HOUR_ONES = 2;
  localparam int BLANK_MIN_TENS  = 1;
  localparam int BLANK_MIN_ONES  = 0;

  function automatic logic [7:0] min_inc(input logic [7:0] mm);
    if (mm[3:0] != BCD_ONES_MAX)     return {mm[7:4], mm[3:0] + 4'd1};
    if (mm[7:4] != BCD_MIN_TENS_MAX) return {mm[7:4] + 4'd1, 4'd0};
    return 8'd0;
  endfunction

  function automatic logic [7:0] hour_inc(input logic [7:0] hh);
    if (hh == HOUR_MAX_BCD)          return 8'd0;
    if (hh[3:0] == BCD_ONES_MAX)     return {hh[7:4] + 4'd1, 4'd0};
    return {hh[7:4], hh[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises a raw active-low button, accepts a level after DEBOUNCE_CYCLES stable cycles, pulses on press.
// Latency: 2 sync + DEBOUNCE_CYCLES cycles, press pulse registered. Backpressure: none.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync[1];
        cnt    <= '0;
        press  <= stable & ~sync[1];  // only the released->pressed edge is an event
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_time_keeper.sv
// HH:MM time base with set-time FSM, 1 Hz colon and edit-digit flash mask for the display mux.
// Latency: all outputs registered, update on the edge consuming a tick or press. Backpressure: none.
module clock_time_keeper #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FLASH_HALF      = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic       colon,
  output logic [3:0] digit_blank,
  output logic [1:0] mode,
  output logic       sec_tick
);
  import clock_pkg::*;

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_HALF - 1);

  mode_e         state, state_n;
  logic          mode_press, inc_press;
  logic [PW-1:0] presc, presc_n;
  logic [5:0]    sec, sec_n;
  logic [FW-1:0] flash_cnt, flash_cnt_n;
  logic          phase, phase_n;
  logic [7:0]    min_n, hour_n;
  logic [3:0]    blank_n;
  logic          inc_ok, tick, leave_set, sec_adv, min_roll;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .btn_n(btn_mode_n), .press(mode_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .rst(rst), .btn_n(btn_inc_n), .press(inc_press)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= MODE_RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      MODE_RUN:      if (mode_press) state_n = MODE_SET_HOUR;
      MODE_SET_HOUR: if (mode_press) state_n = MODE_SET_MIN;
      MODE_SET_MIN:  if (mode_press) state_n = MODE_RUN;
      default:       state_n = MODE_RUN;
    endcase
  end

  always_comb begin
    inc_ok    = inc_press && !mode_press;  // a simultaneous mode press swallows the increment
    tick      = (presc == PRESC_MAX);
    leave_set = (state == MODE_SET_MIN) && (state_n == MODE_RUN);
    sec_adv   = tick && (state == MODE_RUN);
    min_roll  = sec_adv && (sec == SEC_MAX);

    min_n  = {min_tens, min_ones};
    hour_n = {hour_tens, hour_ones};
    if (min_roll) begin
      min_n = min_inc({min_tens, min_ones});
      if ({min_tens, min_ones} == MIN_MAX_BCD) hour_n = hour_inc({hour_tens, hour_ones});
    end else if (inc_ok && state == MODE_SET_HOUR) begin
      hour_n = hour_inc({hour_tens, hour_ones});
    end else if (inc_ok && state == MODE_SET_MIN) begin
      min_n = min_inc({min_tens, min_ones});
    end

    // leaving edit restarts the second so counting begins from the set minute
    if (leave_set)    sec_n = '0;
    else if (min_roll) sec_n = '0;
    else if (sec_adv)  sec_n = sec + 6'd1;
    else               sec_n = sec;

    presc_n = (tick || leave_set) ? '0 : presc + PW'(1);

    if (state_n != state || inc_ok) begin
      flash_cnt_n = '0;
      phase_n     = 1'b0;
    end else if (flash_cnt == FLASH_MAX) begin
      flash_cnt_n = '0;
      phase_n     = ~phase;
    end else begin
      flash_cnt_n = flash_cnt + FW'(1);
      phase_n     = phase;
    end

    blank_n = '0;
    if (phase_n && state_n == MODE_SET_HOUR) begin
      blank_n[BLANK_HOUR_TENS] = 1'b1;
      blank_n[BLANK_HOUR_ONES] = 1'b1;
    end else if (phase_n && state_n == MODE_SET_MIN) begin
      blank_n[BLANK_MIN_TENS] = 1'b1;
      blank_n[BLANK_MIN_ONES] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {hour_tens, hour_ones, min_tens, min_ones} <= '0;
      sec         <= '0;
      presc       <= '0;
      flash_cnt   <= '0;
      phase       <= 1'b0;
      colon       <= 1'b0;
      sec_tick    <= 1'b0;
      digit_blank <= '0;
    end else begin
      {hour_tens, hour_ones} <= hour_n;
      {min_tens, min_ones}   <= min_n;
      sec         <= sec_n;
      presc       <= presc_n;
      flash_cnt   <= flash_cnt_n;
      phase       <= phase_n;
      colon       <= colon ^ tick;
      sec_tick    <= tick;
      digit_blank <= blank_n;
    end
  end

  assign mode = state;

endmodule
